// File: rtl/alu_arbiter_pkg.sv
// Shared constants and types for the two-port ALU arbiter.
// Opcodes follow the ALU's ALUOperation encoding.
package alu_arbiter_pkg;

  localparam int NPORTS = 2;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_NOR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_LUI = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd9;
  localparam logic [3:0] OP_BNE = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_grant.sv
// Combinational 2-way grant: round-robin on ties,
// or fixed port-0 priority when PRIO_MODE is set.
module alu_rr_grant #(
  parameter bit PRIO_MODE = 1'b0
) (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       gnt_vld,
  output logic       gnt
);

  always_comb begin
    gnt_vld = |valid;
    gnt     = 1'b0;
    unique case (1'b1)
      (valid == 2'b11): gnt = PRIO_MODE ? 1'b0 : ~last_grant;
      (valid == 2'b10): gnt = 1'b1;
      default:          gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with
// registered operands and per-port registered responses.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit PRIO_MODE = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        req_valid,
  input  logic [NPORTS-1:0][3:0]   req_op,
  input  logic [NPORTS-1:0][31:0]  req_a,
  input  logic [NPORTS-1:0][31:0]  req_b,
  input  logic [NPORTS-1:0][4:0]   req_shamt,
  output logic [NPORTS-1:0]        req_ready,
  output logic [NPORTS-1:0]        rsp_valid,
  output logic [NPORTS-1:0][31:0]  rsp_result,
  output logic [NPORTS-1:0]        rsp_zero,
  input  logic [NPORTS-1:0]        rsp_ready,
  output logic [3:0]               alu_op,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [4:0]               alu_shamt,
  input  logic [31:0]              alu_result,
  input  logic                     alu_zero
);

  state_t      state, state_nxt;
  logic        owner;
  logic        last_grant;
  logic        gnt, gnt_vld;
  logic        hs;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [4:0]  sh_q;

  alu_rr_grant #(
    .PRIO_MODE (PRIO_MODE)
  ) u_grant (
    .valid      (req_valid),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt        (gnt)
  );

  // Ready is gated by reset so nothing is offered during reset.
  assign hs = (state == IDLE) && gnt_vld && !reset;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sh_q       <= '0;
      rsp_result <= '0;
      rsp_zero   <= '0;
    end else begin
      if (hs) begin
        op_q       <= req_op[gnt];
        a_q        <= req_a[gnt];
        b_q        <= req_b[gnt];
        sh_q       <= req_shamt[gnt];
        owner      <= gnt;
        last_grant <= gnt;
      end
      if (state == EXEC) begin
        rsp_result[owner] <= alu_result;
        rsp_zero[owner]   <= alu_zero;
      end
    end
  end

  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_shamt = sh_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU;
// a second instance runs in strict-priority mode.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0][3:0]   req_op;
  logic [1:0][31:0]  req_a, req_b;
  logic [1:0][4:0]   req_shamt;
  logic [1:0]        rsp_ready;

  logic [1:0]        req_ready, rsp_valid, rsp_zero;
  logic [1:0][31:0]  rsp_result;
  logic [3:0]        alu_op;
  logic [31:0]       alu_a, alu_b, alu_result;
  logic [4:0]        alu_shamt;
  logic              alu_zero;

  logic [1:0]        rdy1, rv1, z1;
  logic [1:0][31:0]  res1;
  logic [3:0]        op1;
  logic [31:0]       a1, b1, r1;
  logic [4:0]        sh1;
  logic              zr1;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int hs_cyc [2];
  logic [1:0]  prev_rv;
  logic [32:0] sbq0 [$];
  logic [32:0] sbq1 [$];
  logic        gnt_log [$];
  bit          cnt_en = 1'b0;
  int          p0c, p1c;

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_f(input logic [3:0] op,
    input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    r = '0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOR: r = ~(a | b);
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_LUI: r = {b[15:0], 16'h0};
      OP_SRL: r = b >> sh;
      OP_SLL: r = b << sh;
      OP_LW, OP_SW: r = (a + b - 32'h1001_0000) >> 2;
      OP_BNE: r = (a == b) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  assign {alu_zero, alu_result} = alu_f(alu_op, alu_a, alu_b, alu_shamt);
  assign {zr1, r1} = alu_f(op1, a1, b1, sh1);

  alu_arbiter #(.PRIO_MODE(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_ready(rsp_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_shamt(alu_shamt), .alu_result(alu_result),
    .alu_zero(alu_zero)
  );

  alu_arbiter #(.PRIO_MODE(1'b1)) dut_prio (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .req_ready(rdy1), .rsp_valid(rv1),
    .rsp_result(res1), .rsp_zero(z1),
    .rsp_ready(rsp_ready),
    .alu_op(op1), .alu_a(a1), .alu_b(b1),
    .alu_shamt(sh1), .alu_result(r1),
    .alu_zero(zr1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [32:0] e;
    if (reset) begin
      sbq0.delete();
      sbq1.delete();
      prev_rv = '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          e = alu_f(req_op[p], req_a[p], req_b[p], req_shamt[p]);
          if (p == 0) sbq0.push_back(e);
          else        sbq1.push_back(e);
          hs_cyc[p] = cyc;
          gnt_log.push_back(p[0]);
        end
        if (rsp_valid[p] && !prev_rv[p])
          check("latency", cyc - hs_cyc[p], 32'd2);
        if (rsp_valid[p] && rsp_ready[p]) begin
          if ((p == 0 && sbq0.size() == 0) ||
              (p == 1 && sbq1.size() == 0)) begin
            check("spurious_rsp", 32'd1, 32'd0);
          end else begin
            e = (p == 0) ? sbq0.pop_front() : sbq1.pop_front();
            check("rsp_result", rsp_result[p], e[31:0]);
            check("rsp_zero", {31'd0, rsp_zero[p]}, {31'd0, e[32]});
          end
        end
      end
      prev_rv = rsp_valid;
      if (cnt_en) begin
        if (req_valid[0] && rdy1[0]) p0c++;
        if (req_valid[1] && rdy1[1]) p1c++;
      end
    end
  end

  task automatic set_req(input int p, input logic [3:0] op,
    input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    req_valid[p] = 1'b1;
    req_op[p]    = op;
    req_a[p]     = a;
    req_b[p]     = b;
    req_shamt[p] = sh;
  endtask

  task automatic issue(input int p, input logic [3:0] op,
    input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    bit ok;
    ok = 1'b0;
    set_req(p, op, a, b, sh);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[p]) ok = 1'b1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid[p] = 1'b0;
  endtask

  task automatic wait_rsp(input int p);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid[p] && rsp_ready[p]) ok = 1'b1;
    end
    if (!ok) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b11;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_shamt = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_alu_op", {28'd0, alu_op}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_rsp_result", rsp_result[0], 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    req_valid = '0;
    rsp_ready = 2'b11;

    issue(0, OP_ADD, 32'd5, 32'd7, 5'd0);
    wait_rsp(0);
    check("add_result", rsp_result[0], 32'd12);
    check("add_zero", {31'd0, rsp_zero[0]}, 32'd0);
    @(posedge clk); #1;

    issue(1, OP_SUB, 32'd3, 32'd3, 5'd0);
    wait_rsp(1);
    check("sub_result", rsp_result[1], 32'd0);
    check("sub_zero", {31'd0, rsp_zero[1]}, 32'd1);
    @(posedge clk); #1;

    issue(1, OP_LW, 32'h1001_0008, 32'd4, 5'd0);
    wait_rsp(1);
    check("lw_result", rsp_result[1], 32'd3);
    @(posedge clk); #1;

    // Ties from reset: round-robin instance alternates, priority one starves port 1.
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    set_req(0, 4'($urandom_range(0, 10)), $urandom, $urandom, 5'($urandom));
    set_req(1, 4'($urandom_range(0, 10)), $urandom, $urandom, 5'($urandom));
    gnt_log.delete();
    p0c = 0;
    p1c = 0;
    cnt_en = 1'b1;
    repeat (12) @(posedge clk);
    #1 req_valid = '0;
    cnt_en = 1'b0;
    check("rr_count", gnt_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < gnt_log.size())
        check("rr_order", {31'd0, gnt_log[i]}, i % 2);
    check("prio_p0", p0c, 32'd4);
    check("prio_p1", p1c, 32'd0);

    rsp_ready = 2'b10;
    issue(0, OP_SLL, 32'd0, 32'd1, 5'd4);
    set_req(1, OP_OR, 32'hF0, 32'h0F, 5'd0);
    @(negedge clk);
    check("hold_exec_rdy1", {31'd0, req_ready[1]}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid[0]}, 32'd1);
      check("hold_result", rsp_result[0], 32'd16);
      check("hold_rdy1", {31'd0, req_ready[1]}, 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("drain_rdy1", {31'd0, req_ready[1]}, 32'd0);
    @(negedge clk);
    check("resume_rdy1", {31'd0, req_ready[1]}, 32'd1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_rsp(1);
    @(posedge clk); #1;

    issue(0, OP_ADD, 32'd1, 32'd2, 5'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_exec_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_exec_op", {28'd0, alu_op}, 32'd0);
    check("rst_exec_a", alu_a, 32'd0);
    check("rst_exec_res", rsp_result[0], 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_exec_norsp", {30'd0, rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;

    rsp_ready = 2'b00;
    issue(1, OP_ADD, 32'd9, 32'd9, 5'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("resp_pending", {30'd0, rsp_valid}, 32'd2);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_resp_op", {28'd0, alu_op}, 32'd0);
    @(posedge clk);
    #1 set_req(0, OP_NOR, 32'd0, 32'd0, 5'd0);
    set_req(1, OP_LUI, 32'd0, 32'h1234, 5'd0);
    rsp_ready = 2'b11;
    @(negedge clk);
    check("tie_after_rst", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);

    check("sb_empty", sbq0.size() + sbq1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
